// File: rtl/iob_pt_unpack_pkg.sv
// Shared posit field geometry and special-pattern helpers for the posit
// unpack/pack blocks; width helpers are constant functions usable in parameters.
package iob_pt_unpack_pkg;

    // Fraction field width once sign, one regime bit and terminator are removed.
    function automatic int pt_frac_w(input int data_w);
        return data_w - 3;
    endfunction

    // Signed scale width: regime magnitude, exponent bits and a sign bit.
    function automatic int pt_scale_w(input int data_w, input int es);
        return $clog2(data_w - 1) + es + 2;
    endfunction

    // Width of a leading-sign run count that must hold values up to data_w-1.
    function automatic int pt_cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    // Not-a-Real pattern: MSB set, all other bits clear (widths up to 64).
    function automatic logic [63:0] pt_nar_pattern(input int data_w);
        return 64'd1 << (data_w - 1);
    endfunction

    function automatic logic [63:0] pt_zero_pattern(input int data_w);
        return 64'd0 & ((64'd1 << (data_w - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/iob_pt_unpack_cls.sv
// Leading-sign run counter: length of the run of bits equal to the top bit
// of a posit body (the word with its sign bit removed), range 1..W-1.
module iob_cls
    import iob_pt_unpack_pkg::*;
#(
    parameter int W = 32,
    localparam int CNT_W = pt_cnt_w(W)
) (
    input  logic [W-2:0]     data_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic found;

    // First bit differing from the leading bit ends the run; none means the
    // run fills the entire body.
    always_comb begin
        cnt_o = CNT_W'(W - 1);
        found = 1'b0;
        for (int i = W - 3; i >= 0; i--) begin
            if (!found && (data_i[i] != data_i[W-2])) begin
                cnt_o = CNT_W'(W - 2 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_pt_unpack.sv
// Two-stage posit decoder: stage 1 takes the absolute value and counts the
// regime run, stage 2 shifts out the regime and splits exponent/fraction.
module iob_pt_unpack
    import iob_pt_unpack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ES     = 2,
    localparam int FRAC_W  = pt_frac_w(DATA_W),
    localparam int SCALE_W = pt_scale_w(DATA_W, ES)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DATA_W-1:0]  data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               sign_o,
    output logic [SCALE_W-1:0] scale_o,
    output logic [FRAC_W-1:0]  frac_o,
    output logic               zero_o,
    output logic               nar_o
);

    localparam int BODY_W = DATA_W - 1;
    localparam int CNT_W  = pt_cnt_w(DATA_W);
    localparam logic [DATA_W-1:0] NAR_PAT  = DATA_W'(pt_nar_pattern(DATA_W));
    localparam logic [DATA_W-1:0] ZERO_PAT = DATA_W'(pt_zero_pattern(DATA_W));

    // Handshake: a word moves across a boundary on any cycle where its valid
    // and ready are both high; a stage may load whenever it is empty or its
    // content leaves in the same cycle, so bubbles are squeezed out on stalls.

    logic               v1_q, v1_d;
    logic               sign1_q, sign1_d;
    logic [BODY_W-1:0]  body1_q, body1_d;
    logic               zero1_q, zero1_d;
    logic               nar1_q, nar1_d;
    logic [CNT_W-1:0]   run1_q, run1_d;

    logic               v2_q, v2_d;
    logic               sign2_q, sign2_d;
    logic [SCALE_W-1:0] scale2_q, scale2_d;
    logic [FRAC_W-1:0]  frac2_q, frac2_d;
    logic               zero2_q, zero2_d;
    logic               nar2_q, nar2_d;

    logic               ready_c;
    logic               adv2_c;
    logic [BODY_W-1:0]  abs_c;
    logic [CNT_W-1:0]   run_c;

    logic               first_c;
    logic [CNT_W:0]     shamt_c;
    logic [BODY_W-1:0]  shifted_c;
    logic [BODY_W-1:0]  rem_c;
    logic [SCALE_W-1:0] exp_c;
    logic [SCALE_W-1:0] regime_c;
    logic [SCALE_W-1:0] scale_c;
    logic [FRAC_W-1:0]  frac_c;

    // Only the body below the sign bit matters; its negation equals the low
    // bits of the full two's complement.
    assign abs_c = data_i[DATA_W-1] ? -data_i[BODY_W-1:0] : data_i[BODY_W-1:0];

    iob_cls #(
        .W (DATA_W)
    ) u_cls (
        .data_i (abs_c),
        .cnt_o  (run_c)
    );

    // Stage 2 datapath: one barrel shift drops regime run plus terminator.
    always_comb begin
        first_c   = body1_q[BODY_W-1];
        shamt_c   = (CNT_W + 1)'(run1_q) + (CNT_W + 1)'(1);
        shifted_c = body1_q << shamt_c;
        rem_c     = shifted_c << ES;
        exp_c     = SCALE_W'(shifted_c >> (BODY_W - ES));
        regime_c  = first_c ? (SCALE_W'(run1_q) - SCALE_W'(1))
                            : (SCALE_W'(0) - SCALE_W'(run1_q));
        scale_c   = (regime_c << ES) + exp_c;
        frac_c    = FRAC_W'(rem_c >> 2);
    end

    always_comb begin
        ready_c  = !v1_q || !v2_q || ready_i;
        adv2_c   = !v2_q || ready_i;

        v1_d     = v1_q;
        sign1_d  = sign1_q;
        body1_d  = body1_q;
        zero1_d  = zero1_q;
        nar1_d   = nar1_q;
        run1_d   = run1_q;

        v2_d     = v2_q;
        sign2_d  = sign2_q;
        scale2_d = scale2_q;
        frac2_d  = frac2_q;
        zero2_d  = zero2_q;
        nar2_d   = nar2_q;

        if (ready_c) begin
            v1_d = valid_i;
            if (valid_i) begin
                sign1_d = data_i[DATA_W-1];
                body1_d = abs_c;
                zero1_d = (data_i == ZERO_PAT);
                nar1_d  = (data_i == NAR_PAT);
                run1_d  = run_c;
            end
        end

        if (adv2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
                if (zero1_q) begin
                    sign2_d  = 1'b0;
                    scale2_d = '0;
                    frac2_d  = '0;
                    zero2_d  = 1'b1;
                    nar2_d   = 1'b0;
                end else if (nar1_q) begin
                    sign2_d  = 1'b1;
                    scale2_d = '0;
                    frac2_d  = '0;
                    zero2_d  = 1'b0;
                    nar2_d   = 1'b1;
                end else begin
                    sign2_d  = sign1_q;
                    scale2_d = scale_c;
                    frac2_d  = frac_c;
                    zero2_d  = 1'b0;
                    nar2_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            v1_q     <= 1'b0;
            sign1_q  <= 1'b0;
            body1_q  <= '0;
            zero1_q  <= 1'b0;
            nar1_q   <= 1'b0;
            run1_q   <= '0;
            v2_q     <= 1'b0;
            sign2_q  <= 1'b0;
            scale2_q <= '0;
            frac2_q  <= '0;
            zero2_q  <= 1'b0;
            nar2_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            sign1_q  <= sign1_d;
            body1_q  <= body1_d;
            zero1_q  <= zero1_d;
            nar1_q   <= nar1_d;
            run1_q   <= run1_d;
            v2_q     <= v2_d;
            sign2_q  <= sign2_d;
            scale2_q <= scale2_d;
            frac2_q  <= frac2_d;
            zero2_q  <= zero2_d;
            nar2_q   <= nar2_d;
        end
    end

    assign ready_o = ready_c;
    assign valid_o = v2_q;
    assign sign_o  = sign2_q;
    assign scale_o = scale2_q;
    assign frac_o  = frac2_q;
    assign zero_o  = zero2_q;
    assign nar_o   = nar2_q;

endmodule

// File: tb/tb_iob_pt_unpack.sv
// Bench for iob_pt_unpack: an 8-bit/ES=0 and a 32-bit/ES=2 instance, directed
// decodes, randomised streams with backpressure, latency and reset checks.
module tb_iob_pt_unpack;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic       v8_i, r8_o, v8_o, r8_i, sign8, zero8, nar8;
    logic [7:0] d8;
    logic [4:0] scale8;
    logic [4:0] frac8;

    logic        v32_i, r32_o, v32_o, r32_i, sign32, zero32, nar32;
    logic [31:0] d32;
    logic [8:0]  scale32;
    logic [28:0] frac32;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp8_q[$];
    logic [63:0] exp32_q[$];

    iob_pt_unpack #(.DATA_W(8), .ES(0)) u_dut8 (
        .clk_i (clk), .arst_i (arst),
        .valid_i (v8_i), .ready_o (r8_o), .data_i (d8),
        .valid_o (v8_o), .ready_i (r8_i),
        .sign_o (sign8), .scale_o (scale8), .frac_o (frac8),
        .zero_o (zero8), .nar_o (nar8)
    );

    iob_pt_unpack #(.DATA_W(32), .ES(2)) u_dut32 (
        .clk_i (clk), .arst_i (arst),
        .valid_i (v32_i), .ready_o (r32_o), .data_i (d32),
        .valid_o (v32_o), .ready_i (r32_i),
        .sign_o (sign32), .scale_o (scale32), .frac_o (frac32),
        .zero_o (zero32), .nar_o (nar32)
    );

    function automatic logic [63:0] pack(input logic z, input logic n, input logic s,
                                         input int scale, input logic [31:0] frac);
        return {13'b0, z, n, s, 16'(scale), frac};
    endfunction

    // Reference decoder: walks the bits one at a time from below the sign.
    function automatic logic [63:0] model(input logic [31:0] w_in, input int n, input int es);
        logic [31:0] mask, w, a, f;
        logic s, b0;
        int i, k, e, rg;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        w = w_in & mask;
        if (w == 32'd0) return pack(1'b1, 1'b0, 1'b0, 0, 32'd0);
        if (w == (32'd1 << (n - 1))) return pack(1'b0, 1'b1, 1'b1, 0, 32'd0);
        s = w[n-1];
        a = s ? ((~w + 32'd1) & mask) : w;
        i = n - 2;
        b0 = a[i];
        k = 0;
        while (i >= 0 && a[i] == b0) begin
            k++;
            i--;
        end
        rg = b0 ? k - 1 : -k;
        if (i >= 0) i--;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        f = 32'd0;
        for (int j = 0; j < n - 3; j++) begin
            f = {f[30:0], (i >= 0) ? a[i] : 1'b0};
            i--;
        end
        return pack(1'b0, 1'b0, s, rg * (1 << es) + e, f);
    endfunction

    function automatic logic [63:0] obs8();
        return pack(zero8, nar8, sign8, int'($signed(scale8)), 32'(frac8));
    endfunction

    function automatic logic [63:0] obs32();
        return pack(zero32, nar32, sign32, int'($signed(scale32)), 32'(frac32));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accepted input, pop on delivered output, and hold
    // stalled outputs against their previous value.
    logic        stall8 = 1'b0, stall32 = 1'b0;
    logic [63:0] held8, held32, mon8_obs, mon32_obs;

    always @(negedge clk) begin
        if (arst) begin
            stall8 = 1'b0;
        end else begin
            mon8_obs = obs8();
            if (stall8) begin
                check("stall8_valid", 64'(v8_o), 64'd1);
                check("stall8_hold", mon8_obs, held8);
            end
            if (v8_o && r8_i) begin
                tests_run++;
                assert (exp8_q.size() != 0) else begin
                    tests_failed++;
                    $error("FAIL out8_spurious: observed %h expected none", mon8_obs);
                end
                if (exp8_q.size() != 0) check("out8", mon8_obs, exp8_q.pop_front());
            end
            if (v8_i && r8_o) exp8_q.push_back(model(32'(d8), 8, 0));
            stall8 = v8_o && !r8_i;
            held8  = mon8_obs;
        end
    end

    always @(negedge clk) begin
        if (arst) begin
            stall32 = 1'b0;
        end else begin
            mon32_obs = obs32();
            if (stall32) begin
                check("stall32_valid", 64'(v32_o), 64'd1);
                check("stall32_hold", mon32_obs, held32);
            end
            if (v32_o && r32_i) begin
                tests_run++;
                assert (exp32_q.size() != 0) else begin
                    tests_failed++;
                    $error("FAIL out32_spurious: observed %h expected none", mon32_obs);
                end
                if (exp32_q.size() != 0) check("out32", mon32_obs, exp32_q.pop_front());
            end
            if (v32_i && r32_o) exp32_q.push_back(model(d32, 32, 2));
            stall32 = v32_o && !r32_i;
            held32  = mon32_obs;
        end
    end

    task automatic directed8(input string tag, input logic [7:0] w, input logic [63:0] exp);
        v8_i = 1'b1; d8 = w; r8_i = 1'b1;
        step();
        v8_i = 1'b0;
        step();
        @(negedge clk);
        check($sformatf("%s_valid", tag), 64'(v8_o), 64'd1);
        check(tag, obs8(), exp);
        step();
    endtask

    task automatic directed32(input string tag, input logic [31:0] w, input logic [63:0] exp);
        v32_i = 1'b1; d32 = w; r32_i = 1'b1;
        step();
        v32_i = 1'b0;
        step();
        @(negedge clk);
        check($sformatf("%s_valid", tag), 64'(v32_o), 64'd1);
        check(tag, obs32(), exp);
        step();
    endtask

    task automatic drain8();
        int guard = 0;
        r8_i = 1'b1;
        while ((exp8_q.size() != 0 || v8_o) && guard < 20) begin
            step();
            guard++;
        end
        check("drain8", 64'(exp8_q.size()), 64'd0);
    endtask

    task automatic drain32();
        int guard = 0;
        r32_i = 1'b1;
        while ((exp32_q.size() != 0 || v32_o) && guard < 20) begin
            step();
            guard++;
        end
        check("drain32", 64'(exp32_q.size()), 64'd0);
    endtask

    task automatic stream8(input int n);
        logic acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            v8_i = 1'b1;
            d8 = 8'($urandom_range(0, 255));
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                r8_i = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                acc = r8_o;
                step();
                guard++;
            end
            check("stream8_accept", 64'(acc), 64'd1);
        end
        v8_i = 1'b0;
        drain8();
    endtask

    task automatic stream32(input int n);
        logic acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            v32_i = 1'b1;
            d32 = $urandom();
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                r32_i = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                acc = r32_o;
                step();
                guard++;
            end
            check("stream32_accept", 64'(acc), 64'd1);
        end
        v32_i = 1'b0;
        drain32();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        v8_i = 1'b0; d8 = '0; r8_i = 1'b0;
        v32_i = 1'b0; d32 = '0; r32_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid8", 64'(v8_o), 64'd0);
        check("rst_ready8", 64'(r8_o), 64'd1);
        check("rst_out8", obs8(), pack(1'b0, 1'b0, 1'b0, 0, 32'd0));
        check("rst_valid32", 64'(v32_o), 64'd0);
        check("rst_ready32", 64'(r32_o), 64'd1);
        check("rst_out32", obs32(), pack(1'b0, 1'b0, 1'b0, 0, 32'd0));
        step();
        arst = 1'b0;
        step();

        // Directed 8-bit, ES=0 decodes
        directed8("d8_40", 8'h40, pack(1'b0, 1'b0, 1'b0, 0, 32'h00));
        directed8("d8_50", 8'h50, pack(1'b0, 1'b0, 1'b0, 0, 32'h10));
        directed8("d8_60", 8'h60, pack(1'b0, 1'b0, 1'b0, 1, 32'h00));
        directed8("d8_c0", 8'hC0, pack(1'b0, 1'b0, 1'b1, 0, 32'h00));
        directed8("d8_01", 8'h01, pack(1'b0, 1'b0, 1'b0, -6, 32'h00));
        directed8("d8_7f", 8'h7F, pack(1'b0, 1'b0, 1'b0, 6, 32'h00));
        directed8("d8_00", 8'h00, pack(1'b1, 1'b0, 1'b0, 0, 32'h00));
        directed8("d8_80", 8'h80, pack(1'b0, 1'b1, 1'b1, 0, 32'h00));
        directed8("d8_ff", 8'hFF, pack(1'b0, 1'b0, 1'b1, -6, 32'h00));

        // Directed 32-bit, ES=2 decodes
        directed32("d32_40000000", 32'h4000_0000, pack(1'b0, 1'b0, 1'b0, 0, 32'd0));
        directed32("d32_7fffffff", 32'h7FFF_FFFF, pack(1'b0, 1'b0, 1'b0, 120, 32'd0));
        directed32("d32_00000001", 32'h0000_0001, pack(1'b0, 1'b0, 1'b0, -120, 32'd0));
        directed32("d32_80000000", 32'h8000_0000, pack(1'b0, 1'b1, 1'b1, 0, 32'd0));

        // Back-to-back streams with pseudo-random backpressure
        stream8(16);
        stream32(16);

        // Continuous valid with ready high: 2-cycle latency, then full rate
        r8_i = 1'b1;
        v8_i = 1'b1;
        d8 = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("lat8_c0", 64'(v8_o), 64'd0);
        step();
        d8 = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("lat8_c1", 64'(v8_o), 64'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            d8 = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("thru8_valid", 64'(v8_o), 64'd1);
            check("thru8_ready", 64'(r8_o), 64'd1);
            step();
        end
        v8_i = 1'b0;
        drain8();

        // Reset with two words in flight
        r8_i = 1'b0;
        v8_i = 1'b1;
        d8 = 8'h5A;
        step();
        d8 = 8'h3C;
        step();
        v8_i = 1'b0;
        check("flight8_valid", 64'(v8_o), 64'd1);
        #2;
        arst = 1'b1;
        #1;
        check("arst8_valid", 64'(v8_o), 64'd0);
        check("arst8_ready", 64'(r8_o), 64'd1);
        exp8_q.delete();
        step();
        check("arst8_out", obs8(), pack(1'b0, 1'b0, 1'b0, 0, 32'd0));
        #2;
        arst = 1'b0;
        r8_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst8_valid", 64'(v8_o), 64'd0);
            check("post_rst8_ready", 64'(r8_o), 64'd1);
            step();
        end

        // Pipeline usable again after reset
        directed8("d8_after_rst", 8'h60, pack(1'b0, 1'b0, 1'b0, 1, 32'h00));

        check("final_q8", 64'(exp8_q.size()), 64'd0);
        check("final_q32", 64'(exp32_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
